// File: rtl/modexp_pkg.sv
// modexp shared types: operand width, operand type, sequencer states.
// Imported by the multiplier bus interface and the controller.
package modexp_pkg;

    localparam int W = 260;

    typedef logic [W-1:0] op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        MUL_ISSUE,
        MUL_WAIT,
        SQR_ISSUE,
        SQR_WAIT,
        FINISH
    } state_t;

endpackage

// File: rtl/modexp_if.sv
// Bus between the modexp sequencer and the shared modular multiplier.
// master = sequencer, slave = multiplier.
interface modexp_if;
    import modexp_pkg::*;

    logic mm_start;
    op_t  mm_a;
    op_t  mm_b;
    op_t  mm_m;
    op_t  mm_result;
    logic mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );

endinterface

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer driving an external modmul.
// Option: MODEXP_SKIP_LAST_SQUARE_EN drops the final redundant square.
module modexp_ctrl
    import modexp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  op_t  base,
    input  op_t  exp,
    input  op_t  mod,
    output op_t  result,
    output logic done,
    output logic busy,
    modexp_if.master mm
);

    state_t state;
    state_t state_n;
    op_t    r;
    op_t    x;
    op_t    e;
    op_t    m;
    logic   armed;
    logic   last_sq;

    // Only one exponent bit left: the square after it is never used.
    assign last_sq = (e[W-1:1] == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and multiplier bus; operands held through the wait.
    always_comb begin
        state_n     = state;
        mm.mm_start = 1'b0;
        mm.mm_a     = '0;
        mm.mm_b     = '0;
        mm.mm_m     = '0;
        unique case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                state_n = CHECK;
            end
            CHECK: begin
                if (e == '0)  state_n = FINISH;
                else if (e[0]) state_n = MUL_ISSUE;
                else           state_n = SQR_ISSUE;
            end
            MUL_ISSUE: begin
                mm.mm_start = 1'b1;
                mm.mm_a     = r;
                mm.mm_b     = x;
                mm.mm_m     = m;
                state_n     = MUL_WAIT;
            end
            MUL_WAIT: begin
                mm.mm_a = r;
                mm.mm_b = x;
                mm.mm_m = m;
                if (armed && mm.mm_done) state_n = SQR_ISSUE;
            end
            SQR_ISSUE: begin
`ifdef MODEXP_SKIP_LAST_SQUARE_EN
                if (last_sq) begin
                    state_n = CHECK;
                end else begin
                    mm.mm_start = 1'b1;
                    mm.mm_a     = x;
                    mm.mm_b     = x;
                    mm.mm_m     = m;
                    state_n     = SQR_WAIT;
                end
`else
                mm.mm_start = 1'b1;
                mm.mm_a     = x;
                mm.mm_b     = x;
                mm.mm_m     = m;
                state_n     = SQR_WAIT;
`endif
            end
            SQR_WAIT: begin
                mm.mm_a = x;
                mm.mm_b = x;
                mm.mm_m = m;
                if (armed && mm.mm_done) state_n = CHECK;
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand registers, handshake arming and command-side status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r      <= '0;
            x      <= '0;
            e      <= '0;
            m      <= '0;
            armed  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        done <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                LOAD: begin
                    r <= op_t'(1);
                    x <= base;
                    e <= exp;
                    m <= mod;
                end
                MUL_ISSUE: begin
                    armed <= 1'b0;
                end
                MUL_WAIT: begin
                    if (!mm.mm_done) armed <= 1'b1;
                    else if (armed)  r     <= mm.mm_result;
                end
                SQR_ISSUE: begin
                    armed <= 1'b0;
`ifdef MODEXP_SKIP_LAST_SQUARE_EN
                    if (last_sq) e <= '0;
`endif
                end
                SQR_WAIT: begin
                    if (!mm.mm_done) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        x <= mm.mm_result;
                        e <= e >> 1;
                    end
                end
                FINISH: begin
                    result <= r;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                CHECK: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a behavioural modular multiplier.
// The multiplier drives garbage results while busy to expose stale reads.
module tb_modexp_ctrl;
    import modexp_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    op_t  base = '0;
    op_t  exp = '0;
    op_t  mod = '0;
    op_t  result;
    logic done;
    logic busy;

    modexp_if bus ();

    modexp_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .base   (base),
        .exp    (exp),
        .mod    (mod),
        .result (result),
        .done   (done),
        .busy   (busy),
        .mm     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int cnt = 0;
    int pulses = 0;

    function automatic op_t mulmod(op_t a, op_t b, op_t mm);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return op_t'(p % {{W{1'b0}}, mm});
    endfunction

    // Multiplier model: done low for lat cycles after mm_start.
    always @(posedge clk) begin
        if (reset) begin
            bus.mm_done   <= 1'b1;
            bus.mm_result <= '0;
            cnt           <= 0;
        end else if (bus.mm_start) begin
            bus.mm_done   <= 1'b0;
            bus.mm_result <= '1;
            cnt           <= lat;
        end else if (cnt == 1) begin
            bus.mm_done   <= 1'b1;
            bus.mm_result <= mulmod(bus.mm_a, bus.mm_b, bus.mm_m);
            cnt           <= 0;
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end
    end

    // Running count of launched multiplier calls.
    always @(posedge clk) begin
        if (!reset && bus.mm_start) pulses <= pulses + 1;
    end

    task automatic chk(input string nm, input op_t got, input op_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic run_job(input op_t b, input op_t e, input op_t m,
                           input int l, output op_t res, output int np,
                           output int cyc, output logic b1,
                           output logic tmo);
        int p0;
        @(negedge clk);
        lat   = l;
        base  = b;
        exp   = e;
        mod   = m;
        start = 1'b1;
        p0    = pulses;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        b1    = busy;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        tmo = !done;
        res = result;
        np  = pulses - p0;
    endtask

    typedef struct {
        op_t b;
        op_t e;
        op_t m;
        op_t want;
        int  calls;
        int  l;
    } vec_t;

    vec_t vecs[5];
    op_t  p25519;
    op_t  res;
    int   np;
    int   cyc;
    logic b1;
    logic tmo;
    int   n;

    initial begin
        p25519 = (op_t'(1) << 255) - op_t'(19);
        vecs[0] = '{op_t'(3), op_t'(13),  op_t'(7),    op_t'(3),  7, 1};
        vecs[1] = '{op_t'(5), op_t'(0),   op_t'(11),   op_t'(1),  0, 2};
        vecs[2] = '{op_t'(2), op_t'(10),  op_t'(1000), op_t'(24), 6, 3};
        vecs[3] = '{op_t'(2), op_t'(255), p25519,      op_t'(19), 16, 2};
        vecs[4] = '{op_t'(4), op_t'(3),   op_t'(9),    op_t'(1),  4, 4};
`ifdef MODEXP_SKIP_LAST_SQUARE_EN
        foreach (vecs[i]) if (vecs[i].e != '0) vecs[i].calls--;
`endif

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_done", op_t'(done), '0);
        chk("rst_busy", op_t'(busy), '0);
        chk("rst_mm_start", op_t'(bus.mm_start), '0);
        chk("rst_mm_a", bus.mm_a, '0);

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].l,
                    res, np, cyc, b1, tmo);
            chk($sformatf("v%0d_timeout", i), op_t'(tmo), '0);
            chk($sformatf("v%0d_result", i), res, vecs[i].want);
            chk($sformatf("v%0d_calls", i), op_t'(np), op_t'(vecs[i].calls));
            chk($sformatf("v%0d_busy_t1", i), op_t'(b1), op_t'(1));
            chk($sformatf("v%0d_busy_end", i), op_t'(busy), '0);
            if (vecs[i].e == '0)
                chk("exp0_done_cycle", op_t'(cyc), op_t'(4));
        end

        // Reset while the first multiply of a job is outstanding.
        @(negedge clk);
        lat   = 20;
        base  = op_t'(3);
        exp   = op_t'(13);
        mod   = op_t'(7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bus.mm_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_issue_seen", op_t'(bus.mm_start), op_t'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", op_t'(busy), '0);
        chk("midrst_done", op_t'(done), '0);
        chk("midrst_mm_start", op_t'(bus.mm_start), '0);
        run_job(op_t'(4), op_t'(3), op_t'(9), 2, res, np, cyc, b1, tmo);
        chk("postrst_timeout", op_t'(tmo), '0);
        chk("postrst_result", res, op_t'(1));
`ifdef MODEXP_SKIP_LAST_SQUARE_EN
        chk("postrst_calls", op_t'(np), op_t'(3));
`else
        chk("postrst_calls", op_t'(np), op_t'(4));
`endif

        // Second start with new operands while busy must be ignored.
        @(negedge clk);
        lat   = 3;
        base  = op_t'(2);
        exp   = op_t'(10);
        mod   = op_t'(1000);
        start = 1'b1;
        n     = pulses;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        base  = op_t'(3);
        exp   = op_t'(13);
        mod   = op_t'(7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_start_timeout", op_t'(done), op_t'(1));
        chk("busy_start_result", result, op_t'(24));
`ifdef MODEXP_SKIP_LAST_SQUARE_EN
        chk("busy_start_calls", op_t'(pulses - n), op_t'(5));
`else
        chk("busy_start_calls", op_t'(pulses - n), op_t'(6));
`endif
        repeat (3) @(negedge clk);
        chk("hold_done", op_t'(done), op_t'(1));
        chk("hold_result", result, op_t'(24));
        chk("hold_idle_calls", op_t'(bus.mm_start), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
